// File: rtl/interrupt_controller_pkg.sv
// Constants shared between the interrupt controller and the CPU control unit:
// source count, default post-acknowledge holdoff and the controller state encoding.
package interrupt_controller_pkg;

  localparam int IRQ_COUNT              = 8;
  localparam int HOLDOFF_CYCLES_DEFAULT = 8;

  // Line 0 can never interrupt: vector 0x100 - 0 is the boot PC.
  localparam logic [IRQ_COUNT-1:0] IRQ_USABLE = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } irq_state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/acknowledge link between the interrupt controller and the CPU control unit.
//
// Handshake: interrupt_en is a registered level request. While it is high,
// interrupt_num is stable. The control unit ends service with a one-cycle
// interrupt_ack pulse. The controller only honours interrupt_ack while
// interrupt_en is high, and interrupt_en drops on the cycle after the ack.
// state_dbg mirrors the controller FSM.
interface interrupt_controller_if;
  import interrupt_controller_pkg::*;

  logic       interrupt_en;
  logic [2:0] interrupt_num;
  logic       interrupt_ack;
  irq_state_e state_dbg;

  modport ctrl (
    output interrupt_en,
    output interrupt_num,
    output state_dbg,
    input  interrupt_ack
  );

  modport cpu (
    input  interrupt_en,
    input  interrupt_num,
    input  state_dbg,
    output interrupt_ack
  );

endinterface

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// Lowest-index priority encoder over request lines 7..1.
// Bit k of candidates_i stands for line k+1, and index_o is the line number.
module irq_priority_encoder (
  input  logic [6:0] candidates_i,
  output logic       valid_o,
  output logic [2:0] index_o
);

  always_comb begin
    valid_o = |candidates_i;
    index_o = '0;
    // Scan from the top so the lowest set line is written last and wins.
    for (int i = 6; i >= 0; i--) begin
      if (candidates_i[i]) begin
        index_o = 3'(i + 1);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable interrupt controller with lowest-line-first arbitration
// and a fixed holdoff window after every acknowledge.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_COUNT-1:0] irq_lines,
  input  logic                 mask_write_en,
  input  logic [IRQ_COUNT-1:0] mask_in,
  output logic [IRQ_COUNT-1:0] mask_out,
  output logic [IRQ_COUNT-1:0] pending_out,
  interrupt_controller_if.ctrl cpu_if
);

  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  irq_state_e           state_q;
  logic                 int_en_q;
  logic [2:0]           int_num_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IRQ_COUNT-1:0] irq_prev_q;
  logic [IRQ_COUNT-1:0] pending_q, pending_d;
  logic [IRQ_COUNT-1:0] mask_q, mask_d;
  logic [IRQ_COUNT-1:0] edge_det;
  logic [IRQ_COUNT-1:0] clear_vec;
  logic                 ack_taken;
  logic                 cand_valid;
  logic [2:0]           cand_idx;

  assign ack_taken = (state_q == ST_ASSERT) && cpu_if.interrupt_ack;

  always_comb begin
    edge_det  = irq_lines & ~irq_prev_q & IRQ_USABLE;
    clear_vec = '0;
    if (ack_taken) begin
      clear_vec[int_num_q] = 1'b1;
    end
    // The edge term is OR-ed last so a new edge beats a clearing ack.
    pending_d = (pending_q & ~clear_vec) | edge_det;
    mask_d    = mask_write_en ? (mask_in & IRQ_USABLE) : mask_q;
  end

  irq_priority_encoder u_prio (
    .candidates_i (pending_q[7:1] & mask_q[7:1]),
    .valid_o      (cand_valid),
    .index_o      (cand_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= irq_lines;
      pending_q  <= '0;
      mask_q     <= '0;
    end else begin
      irq_prev_q <= irq_lines;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
    end
  end

  // Request/vector registers live in the FSM so nothing combinational
  // links interrupt_ack to interrupt_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      int_en_q  <= 1'b0;
      int_num_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cand_valid) begin
            int_num_q <= cand_idx;
            int_en_q  <= 1'b1;
            state_q   <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (cpu_if.interrupt_ack) begin
            int_en_q <= 1'b0;
            cnt_q    <= CNT_W'(HOLDOFF_CYCLES - 1);
            state_q  <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          int_en_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign mask_out             = mask_q;
  assign pending_out          = pending_q;
  assign cpu_if.interrupt_en  = int_en_q;
  assign cpu_if.interrupt_num = int_num_q;
  assign cpu_if.state_dbg     = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: stimulus pushes the vector it
// expects into exp_q and a negedge monitor pops it on each new request.
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_lines;
  logic       mask_write_en;
  logic [7:0] mask_in;
  logic [7:0] mask_out;
  logic [7:0] pending_out;

  interrupt_controller_if cpu_if ();

  interrupt_controller #(.HOLDOFF_CYCLES(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_lines     (irq_lines),
    .mask_write_en (mask_write_en),
    .mask_in       (mask_in),
    .mask_out      (mask_out),
    .pending_out   (pending_out),
    .cpu_if        (cpu_if.ctrl)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] exp_q[$];
  logic       en_prev  = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_write_en = 1'b1;
    mask_in       = v;
    tick(1);
    mask_write_en = 1'b0;
  endtask

  // Pulse ack in ASSERT, check the clear, then sit out the holdoff window.
  task automatic ack_and_holdoff(input string name, input logic [7:0] exp_pending);
    cpu_if.interrupt_ack = 1'b1;
    tick(1);
    cpu_if.interrupt_ack = 1'b0;
    check({name, "_ack_en"}, {7'd0, cpu_if.interrupt_en}, 8'h00);
    check({name, "_ack_pending"}, pending_out, exp_pending);
    tick(HOLD);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (cpu_if.interrupt_en && !en_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_request", {5'd0, cpu_if.interrupt_num}, 8'hFF);
      end else begin
        check("vector", {5'd0, cpu_if.interrupt_num}, {5'd0, exp_q.pop_front()});
      end
    end
    en_prev = cpu_if.interrupt_en;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst                  = 1'b1;
    irq_lines            = 8'h00;
    mask_write_en        = 1'b0;
    mask_in              = 8'h00;
    cpu_if.interrupt_ack = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_mask", mask_out, 8'h00);
    check("rst_pending", pending_out, 8'h00);
    check("rst_en", {7'd0, cpu_if.interrupt_en}, 8'h00);
    check("rst_num", {5'd0, cpu_if.interrupt_num}, 8'h00);
    check("rst_state", 8'(cpu_if.state_dbg), 8'(ST_IDLE));

    // Single source, 2-cycle latency, ack clears pending.
    write_mask(8'h04);
    check("t1_mask", mask_out, 8'h04);
    irq_lines = 8'h04;
    exp_q.push_back(3'd2);
    tick(1);
    irq_lines = 8'h00;
    check("t1_pend", pending_out, 8'h04);
    check("t1_en_early", {7'd0, cpu_if.interrupt_en}, 8'h00);
    tick(1);
    check("t1_en_lat2", {7'd0, cpu_if.interrupt_en}, 8'h01);
    ack_and_holdoff("t1", 8'h00);
    check("t1_idle", 8'(cpu_if.state_dbg), 8'(ST_IDLE));

    // Simultaneous lines 5 and 3: lowest first, second after holdoff.
    write_mask(8'hFE);
    irq_lines = 8'h28;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd5);
    tick(1);
    irq_lines = 8'h00;
    check("t2_pend", pending_out, 8'h28);
    tick(1);
    check("t2_en_first", {7'd0, cpu_if.interrupt_en}, 8'h01);
    ack_and_holdoff("t2a", 8'h20);
    check("t2_holdoff_en", {7'd0, cpu_if.interrupt_en}, 8'h00);
    tick(1);
    check("t2_en_second", {7'd0, cpu_if.interrupt_en}, 8'h01);
    ack_and_holdoff("t2b", 8'h00);

    // Line 0 is reserved; mask bit 0 is forced low.
    write_mask(8'hFF);
    check("t3_mask", mask_out, 8'hFE);
    irq_lines = 8'h01;
    tick(1);
    irq_lines = 8'h00;
    tick(3);
    check("t3_pend", pending_out, 8'h00);
    check("t3_en", {7'd0, cpu_if.interrupt_en}, 8'h00);

    // Pending while masked, served once unmasked.
    write_mask(8'h00);
    irq_lines = 8'h40;
    tick(1);
    irq_lines = 8'h00;
    tick(3);
    check("t4_pend", pending_out, 8'h40);
    check("t4_en_masked", {7'd0, cpu_if.interrupt_en}, 8'h00);
    exp_q.push_back(3'd6);
    write_mask(8'h40);
    check("t4_en_early", {7'd0, cpu_if.interrupt_en}, 8'h00);
    tick(1);
    check("t4_en", {7'd0, cpu_if.interrupt_en}, 8'h01);
    ack_and_holdoff("t4", 8'h00);

    // New edge on the serviced line during ack: set wins, re-served.
    write_mask(8'h10);
    irq_lines = 8'h10;
    exp_q.push_back(3'd4);
    tick(1);
    irq_lines = 8'h00;
    tick(1);
    check("t5_en", {7'd0, cpu_if.interrupt_en}, 8'h01);
    irq_lines = 8'h10;
    exp_q.push_back(3'd4);
    ack_and_holdoff("t5a", 8'h10);
    irq_lines = 8'h00;
    tick(1);
    check("t5_reassert", {7'd0, cpu_if.interrupt_en}, 8'h01);
    ack_and_holdoff("t5b", 8'h00);

    // Reset mid-ASSERT with the line still held high.
    write_mask(8'h02);
    irq_lines = 8'h02;
    exp_q.push_back(3'd1);
    tick(2);
    check("t6_en", {7'd0, cpu_if.interrupt_en}, 8'h01);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_en", {7'd0, cpu_if.interrupt_en}, 8'h00);
    check("t6_rst_pend", pending_out, 8'h00);
    write_mask(8'h02);
    tick(4);
    check("t6_held_pend", pending_out, 8'h00);
    check("t6_held_en", {7'd0, cpu_if.interrupt_en}, 8'h00);
    irq_lines = 8'h00;
    tick(2);

    // ---------------- final report ----------------
    check("exp_q_drained", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
